// File: rtl/npg_spi_config.sv
// npg_spi_config: SPI-slave shadowed configuration register file for the NPG.
// Host writes hit shadow registers; an apply copies them to the live outputs only while no pulse is active.
module npg_spi_config #(
  parameter int ELEC_W = 32,
  parameter int DEF_AMP = 50,
  parameter int DEF_FREQ = 2000,
  parameter int DEF_PHASE = 4,
  parameter int DEF_RAMP = 50,
  parameter int DEF_RFACT = 16,
  parameter int DEF_ON = 50,
  parameter int DEF_OFF = 50,
  parameter logic [ELEC_W-1:0] DEF_ELE1 = 32'h0000_8000,
  parameter logic [ELEC_W-1:0] DEF_ELE2 = 32'h0000_4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic              pulse_active,
  output logic [5:0]        amplitude,
  output logic [11:0]       freq,
  output logic [2:0]        phaseDuration,
  output logic [5:0]        ramp,
  output logic [9:0]        ramp_factor,
  output logic [7:0]        ON_time,
  output logic [9:0]        OFF_time,
  output logic [ELEC_W-1:0] electrode1,
  output logic [ELEC_W-1:0] electrode2,
  output logic              enable,
  output logic              config_pending,
  output logic              frame_error
);
  logic [1:0] sck_q, cs_q, mosi_q;
  logic sck_d, cs_d, armed;
  logic [5:0] cnt;
  logic [38:0] sr;
  logic [31:0] so, rdata;
  logic [7:0] wr_cnt;
  logic [39:0] frame;
  logic [6:0] rd_addr;
  logic sck_rise, sck_fall, cs_rise, step, wr_en;
  logic [5:0] amp_s, ramp_s;
  logic [11:0] freq_s;
  logic [2:0] phase_s;
  logic [9:0] rfact_s, off_s;
  logic [7:0] on_s;
  logic [ELEC_W-1:0] ele1_s, ele2_s;
  assign sck_rise = sck_q[1] & ~sck_d;
  assign sck_fall = ~sck_q[1] & sck_d;
  assign cs_rise = cs_q[1] & ~cs_d;
  assign frame = {sr, mosi_q[1]};
  assign rd_addr = frame[6:0];
  assign step = armed & ~cs_q[1] & sck_rise & (cnt != 6'd40);
  assign wr_en = step & (cnt == 6'd39) & frame[39];
  always_comb begin
    case (rd_addr)
      7'h00: rdata = 32'(amp_s);
      7'h01: rdata = 32'(freq_s);
      7'h02: rdata = 32'(phase_s);
      7'h03: rdata = 32'(ramp_s);
      7'h04: rdata = 32'(rfact_s);
      7'h05: rdata = 32'(on_s);
      7'h06: rdata = 32'(off_s);
      7'h07: rdata = 32'(ele1_s);
      7'h08: rdata = 32'(ele2_s);
      7'h09: rdata = {31'b0, enable};
      7'h0A: rdata = {16'b0, wr_cnt, 6'b0, pulse_active, config_pending};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {sck_q, cs_q, mosi_q} <= '0;
      {sck_d, cs_d, armed} <= '0;
      cnt <= '0;
      sr <= '0;
      so <= '0;
      miso <= 1'b0;
      wr_cnt <= '0;
      enable <= 1'b0;
      config_pending <= 1'b0;
      frame_error <= 1'b0;
      amp_s <= 6'(DEF_AMP);
      freq_s <= 12'(DEF_FREQ);
      phase_s <= 3'(DEF_PHASE);
      ramp_s <= 6'(DEF_RAMP);
      rfact_s <= 10'(DEF_RFACT);
      on_s <= 8'(DEF_ON);
      off_s <= 10'(DEF_OFF);
      ele1_s <= DEF_ELE1;
      ele2_s <= DEF_ELE2;
      amplitude <= 6'(DEF_AMP);
      freq <= 12'(DEF_FREQ);
      phaseDuration <= 3'(DEF_PHASE);
      ramp <= 6'(DEF_RAMP);
      ramp_factor <= 10'(DEF_RFACT);
      ON_time <= 8'(DEF_ON);
      OFF_time <= 10'(DEF_OFF);
      electrode1 <= DEF_ELE1;
      electrode2 <= DEF_ELE2;
    end else begin
      sck_q <= {sck_q[0], sck};
      cs_q <= {cs_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
      sck_d <= sck_q[1];
      cs_d <= cs_q[1];
      frame_error <= cs_rise & (cnt != 6'd0) & (cnt != 6'd40);
      // armed stays low after reset until cs_n is seen high, discarding any frame in flight
      if (cs_q[1]) begin
        cnt <= '0;
        miso <= 1'b0;
        armed <= 1'b1;
      end else if (armed) begin
        if (step) begin
          cnt <= cnt + 6'd1;
          sr <= frame[38:0];
          if (cnt == 6'd7) so <= frame[7] ? 32'b0 : rdata;
        end
        if (sck_fall) begin
          miso <= (cnt >= 6'd8) ? so[31] : 1'b0;
          if (cnt >= 6'd8) so <= {so[30:0], 1'b0};
        end
      end
      if (wr_en) begin
        wr_cnt <= wr_cnt + 8'd1;
        case (frame[38:32])
          7'h00: amp_s <= frame[5:0];
          7'h01: freq_s <= frame[11:0];
          7'h02: phase_s <= frame[2:0];
          7'h03: ramp_s <= frame[5:0];
          7'h04: rfact_s <= frame[9:0];
          7'h05: on_s <= frame[7:0];
          7'h06: off_s <= frame[9:0];
          7'h07: ele1_s <= ELEC_W'(frame[31:0]);
          7'h08: ele2_s <= ELEC_W'(frame[31:0]);
          7'h09: enable <= frame[0];
          default: ;
        endcase
      end
      if (config_pending) config_pending <= pulse_active;
      else if (wr_en && frame[38:32] == 7'h09 && frame[1]) config_pending <= 1'b1;
      if (config_pending && !pulse_active) begin
        amplitude <= amp_s;
        freq <= freq_s;
        phaseDuration <= phase_s;
        ramp <= ramp_s;
        ramp_factor <= rfact_s;
        ON_time <= on_s;
        OFF_time <= off_s;
        electrode1 <= ele1_s;
        electrode2 <= ele2_s;
      end
    end
  end
endmodule

// File: tb/tb_npg_spi_config.sv
// tb_npg_spi_config: randomized and directed SPI traffic checked against a register-map model.
module tb_npg_spi_config;
  localparam int H = 5;
  localparam int W[9] = '{6, 12, 3, 6, 10, 8, 10, 32, 32};
  localparam logic [31:0] DEF[9] = '{50, 2000, 4, 50, 16, 50, 50, 32'h8000, 32'h4000};
  logic clk = 0, reset = 1, sck = 0, cs_n = 1, mosi = 0, pulse_active = 0;
  logic miso, enable, config_pending, frame_error;
  logic [5:0] amplitude, ramp;
  logic [11:0] freq;
  logic [2:0] phaseDuration;
  logic [9:0] ramp_factor, OFF_time;
  logic [7:0] ON_time;
  logic [31:0] electrode1, electrode2;
  int total = 0, bad = 0, pend_cyc = 0, ferr_cyc = 0;
  logic [31:0] sh[9], lv[9];
  logic m_en, m_pend;
  logic [7:0] m_wc;
  logic [39:0] rx;

  npg_spi_config dut (.clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .pulse_active(pulse_active), .amplitude(amplitude), .freq(freq), .phaseDuration(phaseDuration),
    .ramp(ramp), .ramp_factor(ramp_factor), .ON_time(ON_time), .OFF_time(OFF_time),
    .electrode1(electrode1), .electrode2(electrode2), .enable(enable),
    .config_pending(config_pending), .frame_error(frame_error));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (config_pending) pend_cyc++;
    if (frame_error) ferr_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int a);
    return (W[a] == 32) ? 32'hFFFF_FFFF : (32'd1 << W[a]) - 32'd1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 9; i++) begin
      sh[i] = DEF[i];
      lv[i] = DEF[i];
    end
    m_en = 0;
    m_pend = 0;
    m_wc = 0;
  endtask

  task automatic m_settle();
    if (m_pend && !pulse_active) begin
      lv = sh;
      m_pend = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    if (a < 9) return sh[a];
    if (a == 9) return {31'b0, m_en};
    if (a == 10) return {16'b0, m_wc, 6'b0, pulse_active, m_pend};
    return 0;
  endfunction

  task automatic check_live();
    check("amplitude", 32'(amplitude), lv[0]);
    check("freq", 32'(freq), lv[1]);
    check("phaseDuration", 32'(phaseDuration), lv[2]);
    check("ramp", 32'(ramp), lv[3]);
    check("ramp_factor", 32'(ramp_factor), lv[4]);
    check("ON_time", 32'(ON_time), lv[5]);
    check("OFF_time", 32'(OFF_time), lv[6]);
    check("electrode1", electrode1, lv[7]);
    check("electrode2", electrode2, lv[8]);
    check("enable", 32'(enable), 32'(m_en));
    check("config_pending", 32'(config_pending), 32'(m_pend));
  endtask

  task automatic spi_bits(input logic [39:0] tx, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mosi = tx[39-i];
      repeat (H) @(negedge clk);
      rx[39-i] = miso;
      sck = 1;
      repeat (H) @(negedge clk);
      sck = 0;
    end
  endtask

  task automatic spi_xfer(input logic [39:0] tx, input int nbits);
    rx = '0;
    cs_n = 0;
    spi_bits(tx, 0, nbits);
    repeat (H) @(negedge clk);
    cs_n = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    spi_xfer({1'b1, 7'(a), d}, 40);
    m_wc++;
    if (a < 9) sh[a] = d & mask(a);
    else if (a == 9) begin
      m_en = d[0];
      if (d[1]) m_pend = 1;
    end
    m_settle();
  endtask

  task automatic rd(input int a);
    logic [31:0] exp;
    exp = m_read(a);
    spi_xfer({1'b0, 7'(a), 32'h0}, 40);
    check("read_hdr", 32'(rx[39:32]), 32'h0);
    check($sformatf("read_%0h", a), rx[31:0], exp);
  endtask

  initial begin
    int p0, f0, op, a;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
    repeat (4) @(negedge clk);
    check_live();
    check("miso_reset", 32'(miso), 0);
    // shadowed write, then apply with no pulse
    wr(0, 37);
    check("amp_before_apply", 32'(amplitude), 50);
    p0 = pend_cyc;
    wr(9, 2);
    check("pending_cycles", pend_cyc - p0, 1);
    check_live();
    // apply blocked by an active pulse
    pulse_active = 1;
    wr(1, 400);
    wr(9, 2);
    check_live();
    pulse_active = 0;
    @(negedge clk);
    m_settle();
    check("freq_after_release", 32'(freq), 400);
    check_live();
    // readback
    wr(7, 32'hA5A5_0001);
    rd(7);
    rd(10);
    rd(7'h3F);
    // abort after 20 bits
    f0 = ferr_cyc;
    spi_xfer({1'b1, 7'h01, 32'd999}, 20);
    check("abort_ferr", ferr_cyc - f0, 1);
    rd(1);
    wr(1, 123);
    rd(1);
    // reset mid-frame
    f0 = ferr_cyc;
    rx = '0;
    cs_n = 0;
    spi_bits({1'b1, 7'h00, 32'd9}, 0, 30);
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
    spi_bits({1'b1, 7'h00, 32'd9}, 30, 40);
    repeat (H) @(negedge clk);
    cs_n = 1;
    repeat (8) @(negedge clk);
    check("reset_ferr", ferr_cyc - f0, 0);
    check_live();
    rd(0);
    rd(10);
    wr(0, 12);
    wr(9, 3);
    rd(0);
    rd(9);
    check_live();
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 127) : $urandom_range(0, 10);
      if (op == 0) begin
        pulse_active = $urandom_range(0, 1);
        repeat (2) @(negedge clk);
        m_settle();
      end else if (op == 1) wr(9, $urandom_range(0, 3));
      else if (op == 2) wr(a, $urandom());
      else rd(a);
      check_live();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
